v2f_pow_seq: RTL and testbench

V2F_POW_SEQ -- requirements
Module: v2f_pow_seq

---
 rtl/v2f_pkg.sv | 12 +
 rtl/v2f_mul_core.sv | 18 +
 rtl/v2f_pow_seq.sv | 118 +++++++++++
 tb/tb_v2f_pow_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/v2f_pkg.sv
// Shared types and constants for the square-and-multiply power unit.
package v2f_pkg;

   localparam int V2F_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } v2f_state_e;

endpackage

// File: rtl/v2f_mul_core.sv
// Combinational signed multiply that keeps only the low W bits of the product.
module v2f_mul_core
   import v2f_pkg::*;
#(
   parameter int W = V2F_WORD_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // The low W bits of a two's-complement product do not depend on signedness,
   // so a W-bit context multiply gives the int32 wrap-around result directly.
   always_comb begin
      y = a * b;
   end

endmodule

// File: rtl/v2f_pow_seq.sv
// Sequential A**B by square-and-multiply, one exponent bit per RUN cycle.
module v2f_pow_seq
   import v2f_pkg::*;
#(
   parameter int WIDTH = V2F_WORD_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] Y
);

   v2f_state_e       state_q;
   v2f_state_e       state_n;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] exp_q;
   logic             neg_q;

   logic [WIDTH-1:0] acc_prod;
   logic [WIDTH-1:0] base_prod;

   logic             load;
   logic             step;
   logic             fin;

   v2f_mul_core #(.W(WIDTH)) u_mul_acc (
      .a (acc_q),
      .b (base_q),
      .y (acc_prod)
   );

   v2f_mul_core #(.W(WIDTH)) u_mul_base (
      .a (base_q),
      .b (base_q),
      .y (base_prod)
   );

   // Next-state and datapath control decode.
   always_comb begin
      state_n = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            // A negative exponent finishes on the first RUN cycle, matching B=0 timing.
            if (neg_q || (exp_q == '0)) begin
               fin     = 1'b1;
               state_n = FIN;
            end else begin
               step    = 1'b1;
            end
         end
         FIN: begin
            if (START) begin
               load    = 1'b1;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register with registered BUSY/DONE decoded from the next state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state_q <= state_n;
         BUSY    <= (state_n == RUN);
         DONE    <= (state_n == FIN);
      end
   end

   // Operand load, square-and-multiply iteration and result capture.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_q  <= WIDTH'(1);
         base_q <= '0;
         exp_q  <= '0;
         neg_q  <= 1'b0;
         Y      <= '0;
      end else begin
         if (load) begin
            acc_q  <= WIDTH'(1);
            base_q <= A;
            exp_q  <= B;
            neg_q  <= B[WIDTH-1];
         end else if (step) begin
            if (exp_q[0]) begin
               acc_q <= acc_prod;
            end
            base_q <= base_prod;
            exp_q  <= exp_q >> 1;
         end
         if (fin) begin
            Y <= neg_q ? '0 : acc_q;
         end
      end
   end

endmodule

// File: tb/tb_v2f_pow_seq.sv
// Directed self-checking bench for v2f_pow_seq.
module tb_v2f_pow_seq;

   logic        CLK;
   logic        RST_N;
   logic        START;
   logic [31:0] A;
   logic [31:0] B;
   logic        BUSY;
   logic        DONE;
   logic [31:0] Y;

   int n_checks;
   int n_errors;

   v2f_pow_seq #(.WIDTH(32)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .Y     (Y)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
      end
   endtask

   // Waits for DONE after an accepting edge; returns edges counted from edge 0.
   task automatic wait_done(output int edges, output logic busy_ok);
      edges   = 0;
      busy_ok = 1'b1;
      while (!DONE && edges < 40) begin
         if (!BUSY) busy_ok = 1'b0;
         @(posedge CLK); #1;
         edges++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_y, input int lat);
      int   edges;
      logic busy_ok;
      @(negedge CLK);
      A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk({tag, "_busy_on_accept"}, {31'd0, BUSY}, 32'd1);
      wait_done(edges, busy_ok);
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_busy_in_run"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, "_y"}, Y, exp_y);
      @(posedge CLK); #1;
      chk({tag, "_done_pulse"}, {30'd0, DONE, BUSY}, 32'd0);
      chk({tag, "_y_hold"}, Y, exp_y);
   endtask

   initial begin
      int   edges;
      logic busy_ok;
      int   n_done;

      n_checks = 0;
      n_errors = 0;
      RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_busy", {31'd0, BUSY}, 32'd0);
      chk("reset_done", {31'd0, DONE}, 32'd0);
      chk("reset_y", Y, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      run_op("pow_3_5",    32'd3,          32'd5,          32'd243,        4);
      run_op("pow_2_31",   32'd2,          32'd31,         32'h8000_0000,  6);
      run_op("pow_2_32",   32'd2,          32'd32,         32'h0000_0000,  7);
      run_op("pow_m2_3",   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFF8,  3);
      run_op("pow_7_0",    32'd7,          32'd0,          32'd1,          1);
      run_op("pow_5_m1",   32'd5,          32'hFFFF_FFFF,  32'd0,          1);
      run_op("pow_0_0",    32'd0,          32'd0,          32'd1,          1);
      run_op("pow_m1_max", 32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'hFFFF_FFFF,  32);

      // Back-to-back with START held high and operands changed mid-RUN.
      @(negedge CLK);
      A = 32'd3; B = 32'd5; START = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      A = 32'd2; B = 32'd4;
      edges = 2;
      busy_ok = 1'b1;
      while (!DONE && edges < 40) begin
         if (!BUSY) busy_ok = 1'b0;
         @(posedge CLK); #1;
         edges++;
      end
      chk("b2b_first_latency", edges, 4);
      chk("b2b_first_busy", {31'd0, busy_ok}, 32'd1);
      chk("b2b_first_y", Y, 32'd243);
      @(posedge CLK); #1;
      START = 1'b0;
      chk("b2b_accept_in_fin", {31'd0, BUSY}, 32'd1);
      chk("b2b_y_held_in_run", Y, 32'd243);
      wait_done(edges, busy_ok);
      chk("b2b_second_latency", edges, 4);
      chk("b2b_second_y", Y, 32'd16);

      // Abort a long computation with reset.
      @(negedge CLK);
      A = 32'd3; B = 32'h7FFF_FFFF; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (10) @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1;
      chk("abort_busy", {31'd0, BUSY}, 32'd0);
      chk("abort_done", {31'd0, DONE}, 32'd0);
      chk("abort_y", Y, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (DONE || BUSY) n_done++;
      end
      chk("abort_no_done", n_done, 0);

      run_op("pow_2_2", 32'd2, 32'd2, 32'd4, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
